// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// Takes the serial line after the two-stage synchronizer. Each received byte
// is presented as a one-cycle rx_valid pulse. A start bit that is high again
// at its midpoint is treated as a glitch and ignored. A stop bit sampled low
// raises a one-cycle frame_err pulse, and the block then waits for the line
// to return high before it looks for the next frame.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 4)
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   rx_sync   : synchronized serial line, idle high
//   rx_data   : last correctly framed byte
//   rx_valid  : one-cycle pulse, rx_data has just been updated
//   frame_err : one-cycle pulse, stop bit sampled low
//   busy      : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  // The counter holds k-1 on the k-th edge after it is cleared, so each
  // terminal value is one less than the number of cycles being counted.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  // A frame may only begin after the line has been seen high in IDLE. This
  // stops a reset released mid-frame (line low) from starting a bogus frame.
  logic          armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. The defaults here are
      // overridden later in the block when a pulse is needed, so each
      // pulse lasts exactly one cycle.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (armed && !rx_sync) begin
            cnt   <= '0;
            state <= START;
            busy  <= 1'b1;
          end else if (rx_sync) begin
            armed <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              idx   <= '0;
              state <= DATA;
            end else begin
              // The line is high again at the start-bit midpoint, so this was a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_sync;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              // Leave at the stop-bit midpoint, which gives half a bit of
              // margin to catch the next start edge.
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // Stay here through a break or a line held low.
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Two instances run side by side: dut_f uses CLKS_PER_BIT=16 for most
// scenarios, and dut_s uses 868 for the baud-tolerance case. Expected events
// come from frame arithmetic. A pulse is expected at
// start + 1 + HALF + 9*CLKS_PER_BIT. A valid frame carries its own byte, and
// a bad frame leaves rx_data at the last good byte.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CF = 16;
  localparam int CS = 868;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_f = 1'b1;
  logic       rx_s = 1'b1;
  logic [7:0] data_f, data_s;
  logic       valid_f, err_f, busy_f;
  logic       valid_s, err_s, busy_s;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit both_seen = 1'b0;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
    logic       busy;
  } ev_t;

  ev_t evf[$];
  ev_t evs[$];

  uart_rx #(.CLKS_PER_BIT(CF)) dut_f (
    .clk(clk), .rst(rst), .rx_sync(rx_f),
    .rx_data(data_f), .rx_valid(valid_f), .frame_err(err_f), .busy(busy_f)
  );

  uart_rx #(.CLKS_PER_BIT(CS)) dut_s (
    .clk(clk), .rst(rst), .rx_sync(rx_s),
    .rx_data(data_s), .rx_valid(valid_s), .frame_err(err_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if ((valid_f && err_f) || (valid_s && err_s)) both_seen = 1'b1;
    if (valid_f || err_f) evf.push_back('{err_f, data_f, cyc, busy_f});
    if (valid_s || err_s) evs.push_back('{err_s, data_s, cyc, busy_s});
  end

  // Sends one frame with a given bit period. The task is entered and left at a falling edge.
  task automatic send(input bit slow, input logic [7:0] d, input bit stop,
                      input int period, output int st);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    st = cyc;
    for (int i = 0; i < 10; i++) begin
      if (slow) rx_s = fr[i]; else rx_f = fr[i];
      repeat (period) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_f = 1'b1;
    rx_s = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_cyc(input int st, input int clks);
    return st + 1 + clks / 2 + 9 * clks;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({data_f, valid_f, err_f, busy_f} !== 11'h0) begin
      n_bad++; $display("FAIL reset_fast: got %h want 000", {data_f, valid_f, err_f, busy_f});
    end
    n_cmp++;
    if ({data_s, valid_s, err_s, busy_s} !== 11'h0) begin
      n_bad++; $display("FAIL reset_slow: got %h want 000", {data_s, valid_s, err_s, busy_s});
    end
    rst = 1'b1;
    idle(4);
    n_cmp++;
    if (busy_f !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy_f); end
  endtask

  task automatic test_basic;
    int st;
    ev_t e;
    evf.delete();
    send(1'b0, 8'hA5, 1'b1, CF, st);
    n_cmp++;
    if (evf.size() !== 1) begin
      n_bad++; $display("FAIL basic_count: got %0d want 1", evf.size());
    end else begin
      e = evf.pop_front();
      n_cmp++;
      if ({e.err, e.data, e.busy} !== {1'b0, 8'hA5, 1'b0}) begin
        n_bad++; $display("FAIL basic_event: err/data/busy got %b/%h/%b want 0/a5/0", e.err, e.data, e.busy);
      end
      n_cmp++;
      if (e.cyc !== exp_cyc(st, CF)) begin
        n_bad++; $display("FAIL basic_time: got %0d want %0d", e.cyc, exp_cyc(st, CF));
      end
    end
    idle(3);
  endtask

  task automatic test_glitch;
    int st;
    ev_t e;
    evf.delete();
    st = cyc;
    rx_f = 1'b0;
    repeat (4) @(negedge clk);
    rx_f = 1'b1;
    n_cmp++;
    if (busy_f !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high: got %b want 1", busy_f); end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy_f !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_low: got %b want 0", busy_f); end
    idle(20);
    n_cmp++;
    if (evf.size() !== 0) begin n_bad++; $display("FAIL glitch_events: got %0d want 0", evf.size()); end
    evf.delete();
    send(1'b0, 8'h3C, 1'b1, CF, st);
    n_cmp++;
    if (evf.size() !== 1) begin
      n_bad++; $display("FAIL glitch_next_count: got %0d want 1", evf.size());
    end else begin
      e = evf.pop_front();
      n_cmp++;
      if ({e.err, e.data, e.cyc} !== {1'b0, 8'h3C, exp_cyc(st, CF)}) begin
        n_bad++; $display("FAIL glitch_next: got err=%b data=%h cyc=%0d want 0/3c/%0d", e.err, e.data, e.cyc, exp_cyc(st, CF));
      end
    end
    idle(3);
  endtask

  task automatic test_frame_err;
    int st;
    ev_t e;
    send(1'b0, 8'hA5, 1'b1, CF, st);
    evf.delete();
    send(1'b0, 8'h3C, 1'b0, CF, st);
    n_cmp++;
    if (evf.size() !== 1) begin
      n_bad++; $display("FAIL ferr_count: got %0d want 1", evf.size());
    end else begin
      e = evf.pop_front();
      n_cmp++;
      if ({e.err, e.data, e.cyc} !== {1'b1, 8'hA5, exp_cyc(st, CF)}) begin
        n_bad++; $display("FAIL ferr_event: got err=%b data=%h cyc=%0d want 1/a5/%0d", e.err, e.data, e.cyc, exp_cyc(st, CF));
      end
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if (busy_f !== 1'b1) begin n_bad++; $display("FAIL ferr_hold_busy: got %b want 1", busy_f); end
    n_cmp++;
    if (evf.size() !== 0) begin n_bad++; $display("FAIL ferr_hold_events: got %0d want 0", evf.size()); end
    idle(3);
    n_cmp++;
    if (busy_f !== 1'b0) begin n_bad++; $display("FAIL ferr_release_busy: got %b want 0", busy_f); end
    send(1'b0, 8'h81, 1'b1, CF, st);
    n_cmp++;
    if (evf.size() !== 1 || evf[0].err !== 1'b0 || evf[0].data !== 8'h81) begin
      n_bad++; $display("FAIL ferr_recover: got %0d events, first data %h want 1 event data 81",
                        evf.size(), (evf.size() > 0) ? evf[0].data : 8'hxx);
    end
    evf.delete();
    idle(3);
  endtask

  task automatic test_back_to_back;
    int st0, st1;
    evf.delete();
    send(1'b0, 8'h00, 1'b1, CF, st0);
    send(1'b0, 8'hFF, 1'b1, CF, st1);
    n_cmp++;
    if (evf.size() !== 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 2", evf.size());
    end else begin
      n_cmp++;
      if ({evf[0].err, evf[0].data, evf[1].err, evf[1].data} !== {1'b0, 8'h00, 1'b0, 8'hFF}) begin
        n_bad++; $display("FAIL b2b_data: got %h,%h want 00,ff", evf[0].data, evf[1].data);
      end
      n_cmp++;
      if (evf[1].cyc - evf[0].cyc !== 160) begin
        n_bad++; $display("FAIL b2b_spacing: got %0d want 160", evf[1].cyc - evf[0].cyc);
      end
    end
    evf.delete();
    idle(3);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic [9:0] fr;
    int st;
    d  = {4'h0, 4'($urandom)};
    fr = {1'b1, d, 1'b0};
    evf.delete();
    for (int i = 0; i < 5; i++) begin
      rx_f = fr[i];
      repeat (CF) @(negedge clk);
    end
    rx_f = fr[5];
    repeat (CF / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({data_f, valid_f, err_f, busy_f} !== 11'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %h want 000", {data_f, valid_f, err_f, busy_f});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (CF / 2 - 2) @(negedge clk);
    for (int i = 6; i < 10; i++) begin
      rx_f = fr[i];
      repeat (CF) @(negedge clk);
    end
    idle(40);
    n_cmp++;
    if (evf.size() !== 0 || busy_f !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_quiet: got %0d events busy=%b want 0 events busy=0", evf.size(), busy_f);
    end
    evf.delete();
    send(1'b0, 8'h5A, 1'b1, CF, st);
    n_cmp++;
    if (evf.size() !== 1 || evf[0].data !== 8'h5A || evf[0].cyc !== exp_cyc(st, CF)) begin
      n_bad++; $display("FAIL rstmid_next: got %0d events, data %h want 1 event data 5a",
                        evf.size(), (evf.size() > 0) ? evf[0].data : 8'hxx);
    end
    evf.delete();
    idle(3);
  endtask

  task automatic test_random;
    ev_t exp_q[$];
    ev_t e;
    logic [7:0] last_good;
    logic [7:0] d;
    bit stop;
    int st;
    last_good = 8'h00;
    evf.delete();
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      stop = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send(1'b0, d, stop, CF, st);
      if (stop) last_good = d;
      exp_q.push_back('{!stop, last_good, exp_cyc(st, CF), stop ? 1'b0 : 1'b1});
      idle(stop ? $urandom_range(0, 5) : $urandom_range(2, 5));
    end
    n_cmp++;
    if (evf.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d want %0d", evf.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        e = evf[i];
        n_cmp++;
        if ({e.err, e.data, e.cyc, e.busy} !== {exp_q[i].err, exp_q[i].data, exp_q[i].cyc, exp_q[i].busy}) begin
          n_bad++;
          $display("FAIL rand_frame%0d: got err=%b data=%h cyc=%0d busy=%b want err=%b data=%h cyc=%0d busy=%b",
                   i, e.err, e.data, e.cyc, e.busy, exp_q[i].err, exp_q[i].data, exp_q[i].cyc, exp_q[i].busy);
        end
      end
    end
    evf.delete();
  endtask

  task automatic test_slow_stretched;
    int st;
    evs.delete();
    send(1'b1, 8'h55, 1'b1, (CS * 103) / 100, st);
    n_cmp++;
    if (evs.size() !== 1) begin
      n_bad++; $display("FAIL slow_count: got %0d want 1", evs.size());
    end else begin
      n_cmp++;
      if ({evs[0].err, evs[0].data, evs[0].cyc} !== {1'b0, 8'h55, exp_cyc(st, CS)}) begin
        n_bad++; $display("FAIL slow_event: got err=%b data=%h cyc=%0d want 0/55/%0d",
                          evs[0].err, evs[0].data, evs[0].cyc, exp_cyc(st, CS));
      end
    end
    idle(3);
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (both_seen !== 1'b0) begin n_bad++; $display("FAIL pulse_exclusive: got 1 want 0"); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_slow_stretched;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames. It consumes the serial line after the two-stage `d_ff` synchronizer and delivers each received byte as a one-cycle valid pulse. Detection uses a per-bit clock-cycle counter and mid-bit sampling, with start-bit glitch rejection and framing-error reporting. It sits between the synchronizer chain and the receive FIFO / command decoder.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200). Legal range ≥ 4.
- `clk` input, 1 bit: system clock; all logic is rising-edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `rx_sync` input, 1 bit: serial line, already synchronized to `clk`; idle high.
- `rx_data` output, 8 bits: last correctly framed byte.
- `rx_valid` output, 1 bit: one-cycle pulse; `rx_data` is new.
- `frame_err` output, 1 bit: one-cycle pulse; stop bit was sampled low.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- State machine states:
  - IDLE: waits for `rx_sync`==0, then loads the counter with 0 and goes to START.
  - START: counts to HALF = CLKS_PER_BIT/2 (integer division), then samples the line.
    - Sample 0: go to DATA, counter=0, bit index=0.
    - Sample 1: glitch; return to IDLE with no output pulse.
  - DATA: counts CLKS_PER_BIT cycles, then samples `rx_sync` into `shift[index]`, LSB first.
    - After index 7 is sampled, go to STOP.
  - STOP: counts CLKS_PER_BIT cycles, then samples the line.
    - Sample 1: `rx_data`←shift, pulse `rx_valid`, go to IDLE.
    - Sample 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stays until `rx_sync`==1, then goes to IDLE. This rejects break conditions and lines held low.
- Return to IDLE happens at the stop-bit midpoint, leaving half a bit of margin for the next start edge.
- Counter width is $clog2(CLKS_PER_BIT)+1 bits. It saturates at no point; it is cleared on every sample.
- `rx_sync` is not sampled between sample points, so mid-bit glitches are ignored.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - State=IDLE, counter=0, shift=0.
- Reset is asynchronous and may assert mid-frame. It aborts immediately with no pulse. After release, the block requires a fresh high→low edge before it starts a frame.
- Let E0 be the clock edge at which IDLE first sees `rx_sync`==0. Sample points relative to E0:
  - Start bit: E0+HALF.
  - Data bit n (n = 0..7): E0+HALF+(n+1)·CLKS_PER_BIT.
  - Stop bit: E0+HALF+9·CLKS_PER_BIT.
- `rx_valid` or `frame_err` is high for exactly the one cycle following the stop sample edge. `rx_data` is updated on that same edge.
- `busy` rises the cycle after E0. It falls together with the `rx_valid` pulse, or on WAIT_HIGH exit.
- Back-to-back frames: a start edge arriving any time after the stop sample is detected, including the cycle immediately after it.
- `rx_valid` and `frame_err` are never both high.
- There is no backpressure: the consumer must capture `rx_data` on the `rx_valid` cycle or before the next `rx_valid`.

## Test plan
- CLKS_PER_BIT=16: send 0xA5 framed 8N1. Expect exactly one `rx_valid` pulse at E0+8+144, with `rx_data`=8'hA5 and `busy` low on the same cycle.
- Drive `rx_sync` low for 4 cycles, then high. Expect no `rx_valid`, no `frame_err`, and `busy` deasserted after the START sample. The following 0x3C frame is received correctly.
- Send 0xA5, then 0x3C with the stop bit forced low. Expect a `frame_err` pulse and `rx_data` still 8'hA5. Hold the line low 50 cycles: `busy` stays high. Then release the line and send 0x81: `rx_valid` with `rx_data`=8'h81.
- Send 0x00 and 0xFF back-to-back with no idle between the stop bit and the next start. Expect two `rx_valid` pulses 160 cycles apart, with data 8'h00 then 8'hFF.
- Assert `rst` low during data bit 4 of a frame. Expect all outputs 0 immediately. Then complete the remaining bits on the line: no pulse is generated. A subsequent 0x5A frame is received correctly.
- CLKS_PER_BIT=868, send 0x55 with the bit period stretched +3%. Expect `rx_data`=8'h55 and `rx_valid` asserted.
